// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch sequencer for the multicycle core.
// It selects the next PC, runs the imem request handshake and latches the IR.
//
//  state | meaning
//  IDLE  | no fetch outstanding; PC updates are accepted
//  FETCH | imem_req asserted at pc, waiting for imem_ready
//  FAULT | imem did not answer within TIMEOUT cycles; only reset leaves this state
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16,
  parameter int          CNT_W    = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_start,
  input  logic        pc_write,
  input  logic        pc_write_cond,
  input  logic        zero,
  input  logic [1:0]  pc_src,
  input  logic [31:0] seq_pc,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] ir,
  output logic        ir_valid,
  output logic        busy,
  output logic        fetch_fault,
  output logic        proto_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic             pc_en;
  logic             timeout_hit;
  logic [31:0]      pc_next;

  assign pc_en       = pc_write | (pc_write_cond & zero);
  // The last wait cycle is the one whose increment would reach TIMEOUT.
  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    pc_next = pc;
    case (pc_src)
      2'b00:   pc_next = seq_pc;
      2'b01:   pc_next = branch_target;
      2'b10:   pc_next = jump_target;
      default: pc_next = pc;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (fetch_start) state_next = FETCH;
      end
      FETCH: begin
        if (imem_ready)       state_next = IDLE;
        else if (timeout_hit) state_next = FAULT;
      end
      FAULT:   state_next = FAULT;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      pc          <= RESET_PC;
      ir          <= '0;
      ir_valid    <= 1'b0;
      fetch_fault <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE) begin
        if (pc_en) begin
          pc       <= pc_next;
          ir_valid <= 1'b0;
        end
        if (fetch_start) wait_cnt <= '0;
      end else if (pc_en) begin
        proto_err <= 1'b1;
      end
      if (state == FETCH) begin
        if (imem_ready) begin
          ir       <= imem_rdata;
          ir_valid <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
          if (timeout_hit) fetch_fault <= 1'b1;
        end
      end
    end
  end

  assign imem_req  = (state == FETCH);
  assign imem_addr = (state == FETCH) ? pc : 32'h0000_0000;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus random traffic
// compared every cycle against a behavioural model of the fetch unit.
module tb_pc_fetch_unit;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_start, pc_write, pc_write_cond, zero;
  logic [1:0]  pc_src;
  logic [31:0] seq_pc, branch_target, jump_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] pc, ir;
  logic        ir_valid, busy, fetch_fault, proto_err;

  int errors = 0;
  int checks = 0;

  // Model state: mode 0 = idle, 1 = fetching, 2 = faulted.
  int          m_mode;
  int          m_waited;
  logic [31:0] m_pc, m_ir;
  logic        m_valid, m_fault, m_perr;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .fetch_start(fetch_start), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .zero(zero), .pc_src(pc_src), .seq_pc(seq_pc),
    .branch_target(branch_target), .jump_target(jump_target), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .pc(pc), .ir(ir), .ir_valid(ir_valid), .busy(busy),
    .fetch_fault(fetch_fault), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic quiet();
    reset = 0; fetch_start = 0; pc_write = 0; pc_write_cond = 0; zero = 0;
    pc_src = 2'b11; imem_ready = 0; imem_rdata = 32'h0;
  endtask

  task automatic model_step();
    logic upd;
    upd = pc_write || (pc_write_cond && zero);
    if (reset) begin
      m_mode = 0; m_waited = 0; m_pc = 32'h0; m_ir = 32'h0;
      m_valid = 0; m_fault = 0; m_perr = 0;
    end else if (m_mode == 0) begin
      if (upd) begin
        if (pc_src == 2'b00) m_pc = seq_pc;
        else if (pc_src == 2'b01) m_pc = branch_target;
        else if (pc_src == 2'b10) m_pc = jump_target;
        m_valid = 0;
      end
      if (fetch_start) begin
        m_mode = 1; m_waited = 0;
      end
    end else begin
      if (upd) m_perr = 1;
      if (m_mode == 1) begin
        if (imem_ready) begin
          m_ir = imem_rdata; m_valid = 1; m_mode = 0;
        end else begin
          m_waited++;
          if (m_waited == TIMEOUT) begin
            m_fault = 1; m_mode = 2;
          end
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("pc", pc, m_pc);
    chk("ir", ir, m_ir);
    chk("ir_valid", {31'b0, ir_valid}, {31'b0, m_valid});
    chk("imem_req", {31'b0, imem_req}, {31'b0, m_mode == 1});
    chk("imem_addr", imem_addr, (m_mode == 1) ? m_pc : 32'h0);
    chk("busy", {31'b0, busy}, {31'b0, m_mode != 0});
    chk("fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
    chk("proto_err", {31'b0, proto_err}, {31'b0, m_perr});
  endtask

  initial begin
    int req_cycles;
    quiet();
    seq_pc = 0; branch_target = 0; jump_target = 0;
    m_mode = 0; m_waited = 0; m_pc = 0; m_ir = 0; m_valid = 0; m_fault = 0; m_perr = 0;
    #2;

    // Reset held two cycles
    reset = 1; tick(); tick(); quiet();
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);

    // Fetch with ready in the third request cycle
    req_cycles = 0;
    fetch_start = 1; tick(); quiet();
    if (imem_req) req_cycles++;
    tick(); if (imem_req) req_cycles++;
    tick(); if (imem_req) req_cycles++;
    imem_ready = 1; imem_rdata = 32'h8C01_0004; tick(); quiet();
    if (imem_req) req_cycles++;
    chk("fetch_ir", ir, 32'h8C01_0004);
    chk("fetch_valid", {31'b0, ir_valid}, 32'h1);
    chk("fetch_req_cycles", req_cycles, 3);

    // Sequential / conditional / branch updates
    pc_write = 1; pc_src = 2'b00; seq_pc = 32'h10; tick();
    seq_pc = 32'h14; tick(); quiet();
    chk("seq_pc", pc, 32'h14);
    pc_write_cond = 1; zero = 0; pc_src = 2'b01; branch_target = 32'h40; tick(); quiet();
    chk("beq_not_taken", pc, 32'h14);
    pc_write_cond = 1; zero = 1; pc_src = 2'b01; branch_target = 32'h40; tick(); quiet();
    chk("beq_taken", pc, 32'h40);

    // PC write during FETCH, then reset mid-fetch
    fetch_start = 1; tick(); quiet();
    pc_write = 1; pc_src = 2'b00; seq_pc = 32'h99; tick(); quiet();
    chk("busy_pc_hold", pc, 32'h40);
    chk("proto_err_set", {31'b0, proto_err}, 32'h1);
    reset = 1; tick(); quiet();
    chk("midfetch_rst_req", {31'b0, imem_req}, 32'h0);
    chk("midfetch_rst_pc", pc, 32'h0);

    // Timeout with no ready
    fetch_start = 1; tick(); quiet();
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    chk("pre_timeout_fault", {31'b0, fetch_fault}, 32'h0);
    tick();
    chk("timeout_fault", {31'b0, fetch_fault}, 32'h1);
    chk("timeout_req", {31'b0, imem_req}, 32'h0);
    fetch_start = 1; tick(); quiet();
    chk("fault_ignores_start", {31'b0, imem_req}, 32'h0);
    reset = 1; tick(); quiet();

    // Ready in the last allowed cycle
    fetch_start = 1; tick(); quiet();
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    imem_ready = 1; imem_rdata = 32'hCAFE_0001; tick(); quiet();
    chk("late_ready_fault", {31'b0, fetch_fault}, 32'h0);
    chk("late_ready_ir", ir, 32'hCAFE_0001);

    // Jump together with fetch_start
    fetch_start = 1; pc_write = 1; pc_src = 2'b10; jump_target = 32'h0040_0000; tick(); quiet();
    chk("simul_addr", imem_addr, 32'h0040_0000);
    chk("simul_valid", {31'b0, ir_valid}, 32'h0);
    imem_ready = 1; imem_rdata = 32'h1234_5678; tick(); quiet();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      reset         = ($urandom_range(99) == 0);
      fetch_start   = ($urandom_range(3) == 0);
      pc_write      = ($urandom_range(5) == 0);
      pc_write_cond = ($urandom_range(5) == 0);
      zero          = $urandom_range(1);
      pc_src        = 2'($urandom_range(3));
      seq_pc        = $urandom;
      branch_target = $urandom;
      jump_target   = $urandom;
      imem_ready    = ($urandom_range(3) == 0);
      imem_rdata    = $urandom;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
